// File: rtl/mul_pkg.sv
// Shared types and arithmetic helpers for the multiply result combiner.
// The low 32 bits of a 32x32 product only need lo*lo plus the low halves
// of the two cross products shifted up by 16.
package mul_pkg;

  localparam int MUL_DATA_W = 32;
  localparam int MUL_HALF_W = 16;
  localparam int MUL_TAG_W  = 5;

  typedef struct packed {
    logic [MUL_DATA_W-1:0] result;
    logic [MUL_TAG_W-1:0]  tag;
  } mul_entry_t;

  // Low 16 bits of the cross-product sum; the low half of a sum depends
  // only on the low halves of its operands, so upper bits drop out here.
  function automatic logic [MUL_HALF_W-1:0] mul_mid(
    input logic [MUL_DATA_W-1:0] p2,
    input logic [MUL_DATA_W-1:0] p3
  );
    return MUL_HALF_W'(p2 + p3);
  endfunction

  // Final add of lo*lo and the shifted mid sum, carry out of bit 31 dropped.
  function automatic logic [MUL_DATA_W-1:0] mul_merge(
    input logic [MUL_DATA_W-1:0] p1,
    input logic [MUL_HALF_W-1:0] mid
  );
    return p1 + {mid, {MUL_HALF_W{1'b0}}};
  endfunction

  function automatic logic [MUL_DATA_W-1:0] mul_combine_lo(
    input logic [MUL_DATA_W-1:0] p1,
    input logic [MUL_DATA_W-1:0] p2,
    input logic [MUL_DATA_W-1:0] p3
  );
    return mul_merge(p1, mul_mid(p2, p3));
  endfunction

endpackage

// File: rtl/mul_skid_buffer.sv
// Output register with a one-entry skid behind it. The skid catches the
// registered entry when downstream stalls while a new entry arrives, and
// the output always shows the skid first so ordering is preserved.
// in_ready is a function of registered state only.
module mul_skid_buffer #(
  parameter int W = 37
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_vld;
  logic         skid_vld;
  logic [W-1:0] main_data;
  logic [W-1:0] skid_data;
  logic         load;
  logic         capture;
  logic         main_drain;
  logic         skid_drain;

  // With the skid empty, the main register can always take a new entry:
  // its old contents either leave downstream or move into the skid.
  assign in_ready   = !skid_vld || !main_vld;
  assign load       = in_valid && in_ready && !flush;
  assign capture    = load && main_vld && !skid_vld && !out_ready;
  assign main_drain = main_vld && !skid_vld && out_ready;
  assign skid_drain = skid_vld && out_ready;

  assign out_valid = main_vld || skid_vld;
  assign out_data  = skid_vld ? skid_data : main_data;

  // Occupancy tracking; flush empties both entries.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (flush) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else begin
      if (load)            main_vld <= 1'b1;
      else if (main_drain) main_vld <= 1'b0;
      if (capture)         skid_vld <= 1'b1;
      else if (skid_drain) skid_vld <= 1'b0;
    end
  end

  // Payload registers; cleared on reset so the output reads zero, untouched by flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_data <= '0;
      skid_data <= '0;
    end else begin
      if (load)    main_data <= in_data;
      if (capture) skid_data <= main_data;
    end
  end

endmodule

// File: rtl/mul_result_combiner.sv
// Combines the registered 16x16 partial products from the multiplier cell
// into the low 32 bits of the 32x32 product and hands it, with its
// destination tag, to writeback through a skid-buffered output stage.
module mul_result_combiner
  import mul_pkg::*;
#(
  parameter int DATA_W    = MUL_DATA_W,
  parameter int TAG_W     = MUL_TAG_W,
  parameter int SPLIT_ADD = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] M_mul_cell_p1,
  input  logic [DATA_W-1:0] M_mul_cell_p2,
  input  logic [DATA_W-1:0] M_mul_cell_p3,
  input  logic              M_mul_valid,
  output logic              M_mul_ready,
  input  logic [TAG_W-1:0]  M_mul_tag,
  input  logic              flush,
  output logic [DATA_W-1:0] A_mul_result,
  output logic [TAG_W-1:0]  A_mul_tag,
  output logic              A_mul_valid,
  input  logic              A_mul_ready
);

  localparam int PAY_W = DATA_W + TAG_W;

  logic              s2_in_valid;
  logic              s2_in_ready;
  logic [DATA_W-1:0] s2_in_result;
  logic [TAG_W-1:0]  s2_in_tag;
  logic [PAY_W-1:0]  s2_out_data;

  generate
    if (SPLIT_ADD != 0) begin : g_split
      logic                  vld_p1;
      logic [DATA_W-1:0]     prod_lo_p1;
      logic [MUL_HALF_W-1:0] mid_p1;
      logic [TAG_W-1:0]      tag_p1;
      logic                  in_fire;

      // S1 can take a new op when empty or when its op moves into S2 this cycle.
      assign M_mul_ready = !vld_p1 || s2_in_ready;
      assign in_fire     = M_mul_valid && M_mul_ready && !flush;

      // ---- stage S1 boundary: lo*lo and mid sum ----
      // S1 occupancy; an op presented alongside flush is dropped.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)         vld_p1 <= 1'b0;
        else if (flush)       vld_p1 <= 1'b0;
        else if (in_fire)     vld_p1 <= 1'b1;
        else if (s2_in_ready) vld_p1 <= 1'b0;
      end

      // S1 payload, loaded only on an accepted op.
      always_ff @(posedge clk) begin
        if (in_fire) begin
          prod_lo_p1 <= M_mul_cell_p1;
          mid_p1     <= mul_mid(M_mul_cell_p2, M_mul_cell_p3);
          tag_p1     <= M_mul_tag;
        end
      end

      assign s2_in_valid  = vld_p1;
      assign s2_in_result = mul_merge(prod_lo_p1, mid_p1);
      assign s2_in_tag    = tag_p1;
    end else begin : g_single
      assign M_mul_ready  = s2_in_ready;
      assign s2_in_valid  = M_mul_valid;
      assign s2_in_result = mul_combine_lo(M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3);
      assign s2_in_tag    = M_mul_tag;
    end
  endgenerate

  // ---- stage S2 boundary: final result plus skid entry ----
  mul_skid_buffer #(
    .W(PAY_W)
  ) u_out (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (s2_in_valid),
    .in_ready  (s2_in_ready),
    .in_data   ({s2_in_result, s2_in_tag}),
    .out_valid (A_mul_valid),
    .out_ready (A_mul_ready),
    .out_data  (s2_out_data)
  );

  assign A_mul_result = s2_out_data[PAY_W-1:TAG_W];
  assign A_mul_tag    = s2_out_data[TAG_W-1:0];

endmodule

// File: tb/tb_mul_result_combiner.sv
// Directed bench for mul_result_combiner with a queue scoreboard: the
// driver pushes the hand-computed result when an op is accepted and an
// independent monitor pops and compares on every output transfer.
module tb_mul_result_combiner;
  import mul_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] p1, p2, p3;
  logic        m_valid;
  logic        m_ready;
  logic [4:0]  m_tag;
  logic        flush;
  logic [31:0] a_result;
  logic [4:0]  a_tag;
  logic        a_valid;
  logic        a_ready;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  mul_entry_t sb[$];

  mul_result_combiner #(.DATA_W(32), .TAG_W(5), .SPLIT_ADD(1)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .M_mul_cell_p1 (p1),
    .M_mul_cell_p2 (p2),
    .M_mul_cell_p3 (p3),
    .M_mul_valid   (m_valid),
    .M_mul_ready   (m_ready),
    .M_mul_tag     (m_tag),
    .flush         (flush),
    .A_mul_result  (a_result),
    .A_mul_tag     (a_tag),
    .A_mul_valid   (a_valid),
    .A_mul_ready   (a_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every output transfer must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && a_valid === 1'b1 && a_ready === 1'b1) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_output: got result %h tag %0d, expected no output", a_result, a_tag);
      end else begin
        mul_entry_t e;
        e = sb.pop_front();
        chk("out_result", a_result, e.result);
        chk("out_tag", {27'd0, a_tag}, {27'd0, e.tag});
      end
    end
  end

  // Drive one op starting at posedge+1; returns at posedge+1 after acceptance.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                      input logic [4:0] t, input logic [31:0] exp);
    bit acc;
    mul_entry_t e;
    acc = 1'b0;
    e.result = exp;
    e.tag = t;
    p1 = a; p2 = b; p3 = c; m_tag = t; m_valid = 1'b1;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      if (m_ready === 1'b1) begin
        sb.push_back(e);
        acc = 1'b1;
      end
      @(posedge clk); #1;
    end
    m_valid = 1'b0;
    if (!acc) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout: tag %0d not accepted, expected acceptance", t);
    end
  endtask

  // Called right after an accept into an empty pipe: no output yet, then output.
  task automatic check_latency(input string name);
    @(negedge clk);
    chk({name, "_lat_early"}, {31'd0, a_valid}, 32'd0);
    @(negedge clk);
    chk({name, "_lat"}, {31'd0, a_valid}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input string name);
    for (int n = 0; n < 200 && sb.size() != 0; n++) @(negedge clk);
    chk({name, "_drain"}, sb.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_cycles;
    int c0;
    int seen;
    int low;
    int drop_cnt;

    reset_n = 1'b0; flush = 1'b0; m_valid = 1'b0; a_ready = 1'b1;
    p1 = '0; p2 = '0; p3 = '0; m_tag = '0;
    #1;
    chk("reset_a_valid", {31'd0, a_valid}, 32'd0);
    chk("reset_a_result", a_result, 32'd0);
    chk("reset_a_tag", {27'd0, a_tag}, 32'd0);
    chk("reset_m_ready", {31'd0, m_ready}, 32'd1);
    #21 reset_n = 1'b1;
    @(posedge clk); #1;

    // Basic: 0x00030002 * 0x00050004 -> p1=8, p2=10, p3=12.
    send(32'd8, 32'd10, 32'd12, 5'd3, 32'h0016_0008);
    check_latency("basic");

    // Wrap and upper-half independence.
    send(32'hFFFE_0001, 32'hFFFE_0001, 32'hFFFE_0001, 5'd4, 32'h0000_0001);
    send(32'hFFFE_0001, 32'h1234_0001, 32'hABCD_FFFF, 5'd5, 32'hFFFE_0001);
    send(32'd5, 32'h0000_8000, 32'h0000_8000, 5'd6, 32'h0000_0005);
    wait_drain("wrap");

    // Back-to-back stream of 8, tags 0..7.
    c0 = cyc;
    seen = 0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(32'(i), 32'hA5A5_0001, 32'(i), 5'(i), (32'(i + 1) << 16) + 32'(i));
        acc_cycles = cyc - c0;
      end
      begin
        bit found;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
          @(negedge clk);
          if (a_valid === 1'b1) found = 1'b1;
        end
        if (found) begin
          seen = 1;
          for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (a_valid === 1'b1) seen++;
          end
        end
      end
    join
    chk("stream_accept_cycles", acc_cycles, 32'd8);
    chk("stream_output_cycles", seen, 32'd8);
    wait_drain("stream");

    // Stall for 4 cycles during a stream of 6 (tags 8..13).
    low = 0;
    fork
      begin
        for (int i = 8; i < 14; i++)
          send(32'(i), 32'hA5A5_0001, 32'(i), 5'(i), (32'(i + 1) << 16) + 32'(i));
      end
      begin
        bit found;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
          @(negedge clk);
          if (a_valid === 1'b1) found = 1'b1;
        end
        @(posedge clk); #1;
        a_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("stall_hold_valid", {31'd0, a_valid}, 32'd1);
          chk("stall_hold_result", a_result, 32'h000A_0009);
          chk("stall_hold_tag", {27'd0, a_tag}, 32'd9);
          if (m_ready === 1'b0) low = 1;
        end
        @(posedge clk); #1;
        a_ready = 1'b1;
      end
    join
    chk("stall_ready_drop", low, 32'd1);
    wait_drain("stall");

    // Flush with S1, S2 and skid full, downstream stalled.
    a_ready = 1'b0;
    send(32'd20, 32'd0, 32'd0, 5'd20, 32'd20);
    send(32'd21, 32'd0, 32'd0, 5'd21, 32'd21);
    send(32'd22, 32'd0, 32'd0, 5'd22, 32'd22);
    @(negedge clk);
    chk("full_a_valid", {31'd0, a_valid}, 32'd1);
    chk("full_m_ready", {31'd0, m_ready}, 32'd0);
    chk("full_skid_tag", {27'd0, a_tag}, 32'd20);
    flush = 1'b1;
    m_valid = 1'b1; p1 = 32'h99; p2 = '0; p3 = '0; m_tag = 5'd31;
    sb.delete();
    @(posedge clk); #1;
    flush = 1'b0; m_valid = 1'b0; a_ready = 1'b1;
    @(negedge clk);
    chk("flush_a_valid", {31'd0, a_valid}, 32'd0);
    chk("flush_m_ready", {31'd0, m_ready}, 32'd1);
    @(posedge clk); #1;
    // 7 * 6: p1=42, cross products zero.
    send(32'd42, 32'd0, 32'd0, 5'd9, 32'h0000_002A);
    check_latency("post_flush");
    wait_drain("post_flush");

    // Input presented together with flush on an idle pipe is dropped.
    flush = 1'b1; m_valid = 1'b1; p1 = 32'h55; p2 = '0; p3 = '0; m_tag = 5'd30;
    @(posedge clk); #1;
    flush = 1'b0; m_valid = 1'b0;
    drop_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (a_valid === 1'b1) drop_cnt++;
    end
    chk("flush_drop", drop_cnt, 32'd0);
    @(posedge clk); #1;

    // Asynchronous reset between edges with a result on the output.
    send(32'h11, 32'd0, 32'd0, 5'd1, 32'h11);
    send(32'h22, 32'd0, 32'd0, 5'd2, 32'h22);
    #2;
    reset_n = 1'b0;
    sb.delete();
    #1;
    chk("async_reset_a_valid", {31'd0, a_valid}, 32'd0);
    chk("async_reset_a_result", a_result, 32'd0);
    chk("async_reset_a_tag", {27'd0, a_tag}, 32'd0);
    #13 reset_n = 1'b1;
    #1;
    chk("post_reset_m_ready", {31'd0, m_ready}, 32'd1);
    @(posedge clk); #1;
    send(32'h100, 32'd2, 32'd3, 5'd17, 32'h0005_0100);
    check_latency("post_reset");
    wait_drain("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
